// File: rtl/pipe_pkg.sv
// pipe_pkg: shared slot record, forward-select encoding and counter width
package pipe_pkg;
  localparam int RN_MAX = 16;
  localparam int CNT_W = 32;
  localparam int SEL_RF = 0;
  typedef struct packed {
    logic valid;
    logic wreg;
    logic m2reg;
    logic [RN_MAX-1:0] rn;
  } slot_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage request and hazard-control response bundle
interface pipe_hazard_ctrl_if #(parameter int NSTAGE = 3, parameter int RN_W = 5) ();
  localparam int SEL_W = $clog2(NSTAGE + 1);
  logic d_valid, d_wreg, d_m2reg, d_use_rs, d_use_rt, flush;
  logic [RN_W-1:0] d_rn, d_rs, d_rt;
  logic wpcir;
  logic [SEL_W-1:0] fwda, fwdb;
  logic [31:0] stall_cnt, bubble_cnt;
  logic [NSTAGE-1:0] slot_valid;
  modport master (output d_valid, d_wreg, d_m2reg, d_use_rs, d_use_rt, flush, d_rn, d_rs, d_rt,
                  input wpcir, fwda, fwdb, stall_cnt, bubble_cnt, slot_valid);
  modport slave (input d_valid, d_wreg, d_m2reg, d_use_rs, d_use_rt, flush, d_rn, d_rs, d_rt,
                 output wpcir, fwda, fwdb, stall_cnt, bubble_cnt, slot_valid);
endinterface

// File: rtl/pipe_fwd_sel.sv
// pipe_fwd_sel: youngest-match priority encoder with load-use hazard flag
module pipe_fwd_sel import pipe_pkg::*; #(
  parameter int N = 3,
  parameter int LOAD_RDY = 2,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     i_match,
  input  logic [N-1:0]     i_m2reg,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_load_hz
);
  // scan oldest to youngest so the youngest match is written last
  always_comb begin
    o_sel = SEL_W'(SEL_RF);
    o_load_hz = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (i_match[k-1]) begin
        o_sel = SEL_W'(k);
        o_load_hz = i_m2reg[k-1] && (k < LOAD_RDY);
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: post-decode scoreboard driving forwarding selects and load-use stalls
module pipe_hazard_ctrl import pipe_pkg::*; #(
  parameter int NSTAGE = 3,
  parameter int RN_W = 5,
  parameter int LOAD_RDY = 2
) (
  input logic clock,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(NSTAGE + 1);
  slot_t r_slot [NSTAGE];
  logic [NSTAGE-1:0] w_match_a, w_match_b, w_m2reg;
  logic [SEL_W-1:0] w_sel_a, w_sel_b;
  logic w_hz_a, w_hz_b, w_stall, w_load, w_bubble;
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;
  for (genvar k = 0; k < NSTAGE; k++) begin : g_match
    wire w_live = r_slot[k].valid && r_slot[k].wreg;
    assign w_match_a[k] = w_live && r_slot[k].rn == RN_MAX'(bus.d_rs) && bus.d_rs != '0 && bus.d_use_rs;
    assign w_match_b[k] = w_live && r_slot[k].rn == RN_MAX'(bus.d_rt) && bus.d_rt != '0 && bus.d_use_rt;
    assign w_m2reg[k] = r_slot[k].m2reg;
    assign bus.slot_valid[k] = r_slot[k].valid;
  end
  pipe_fwd_sel #(.N(NSTAGE), .LOAD_RDY(LOAD_RDY), .SEL_W(SEL_W)) u_sel_a (
    .i_match(w_match_a), .i_m2reg(w_m2reg), .o_sel(w_sel_a), .o_load_hz(w_hz_a));
  pipe_fwd_sel #(.N(NSTAGE), .LOAD_RDY(LOAD_RDY), .SEL_W(SEL_W)) u_sel_b (
    .i_match(w_match_b), .i_m2reg(w_m2reg), .o_sel(w_sel_b), .o_load_hz(w_hz_b));
  // flush kills the ID instruction, so it can never be the victim of a stall
  assign w_stall = bus.d_valid && !bus.flush && (w_hz_a || w_hz_b);
  assign w_load = bus.d_valid && !w_stall && !bus.flush;
  assign w_bubble = bus.d_valid && (w_stall || bus.flush);
  assign bus.wpcir = !w_stall;
  assign bus.fwda = w_sel_a;
  assign bus.fwdb = w_sel_b;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
  // advance the slot pipeline, inserting a bubble when ID does not issue
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NSTAGE; k++) r_slot[k] <= '0;
    end else begin
      r_slot[0] <= w_load ? slot_t'{1'b1, bus.d_wreg, bus.d_m2reg, RN_MAX'(bus.d_rn)} : '0;
      for (int k = 1; k < NSTAGE; k++) r_slot[k] <= r_slot[k-1];
    end
  end
  // saturating performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall && r_stall_cnt != '1);
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(w_bubble && r_bubble_cnt != '1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios for forwarding, load-use stalls, flush, r0 and reset
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst3 = 1'b0, rst4 = 1'b0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGE(3), .RN_W(5)) if3 ();
  pipe_hazard_ctrl_if #(.NSTAGE(4), .RN_W(5)) if4 ();
  pipe_hazard_ctrl #(.NSTAGE(3), .RN_W(5), .LOAD_RDY(2)) dut3 (.clock(clk), .reset(rst3), .bus(if3.slave));
  pipe_hazard_ctrl #(.NSTAGE(4), .RN_W(5), .LOAD_RDY(3)) dut4 (.clock(clk), .reset(rst4), .bus(if4.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id3(input logic v, w, m, input logic [4:0] rn, rs, rt, input logic urs, urt, fl);
    if3.d_valid = v; if3.d_wreg = w; if3.d_m2reg = m; if3.d_rn = rn;
    if3.d_rs = rs; if3.d_rt = rt; if3.d_use_rs = urs; if3.d_use_rt = urt; if3.flush = fl;
    #1;
  endtask

  task automatic id4(input logic v, w, m, input logic [4:0] rn, rs, rt, input logic urs, urt, fl);
    if4.d_valid = v; if4.d_wreg = w; if4.d_m2reg = m; if4.d_rn = rn;
    if4.d_rs = rs; if4.d_rt = rt; if4.d_use_rs = urs; if4.d_use_rt = urt; if4.flush = fl;
    #1;
  endtask

  task automatic drain3();
    id3(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    id3(0, 0, 0, 0, 0, 0, 0, 0, 0);
    id4(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst3 = 1; rst4 = 1;
    step(); step();
    rst3 = 0; rst4 = 0;
    #1;
    checks++; if (if3.slot_valid !== 3'b000) begin errors++; $display("FAIL rst_slot_valid got=%b exp=000", if3.slot_valid); end
    checks++; if (if3.wpcir !== 1'b1) begin errors++; $display("FAIL rst_wpcir got=%b exp=1", if3.wpcir); end
    checks++; if (if3.fwda !== 2'd0 || if3.fwdb !== 2'd0) begin errors++; $display("FAIL rst_fwd got=%0d/%0d exp=0/0", if3.fwda, if3.fwdb); end
    checks++; if (if3.stall_cnt !== 32'd0 || if3.bubble_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", if3.stall_cnt, if3.bubble_cnt); end
    checks++; if (if4.slot_valid !== 4'b0000 || if4.wpcir !== 1'b1) begin errors++; $display("FAIL rst4 got=%b/%b exp=0000/1", if4.slot_valid, if4.wpcir); end
  endtask

  task automatic test_alu_fwd();
    id3(1, 1, 0, 3, 0, 0, 0, 0, 0);
    step();
    id3(1, 0, 0, 0, 3, 3, 1, 0, 0);
    checks++; if (if3.fwda !== 2'd1) begin errors++; $display("FAIL alu_fwda got=%0d exp=1", if3.fwda); end
    checks++; if (if3.wpcir !== 1'b1) begin errors++; $display("FAIL alu_wpcir got=%b exp=1", if3.wpcir); end
    checks++; if (if3.fwdb !== 2'd0) begin errors++; $display("FAIL alu_fwdb_unused got=%0d exp=0", if3.fwdb); end
    step();
    drain3();
  endtask

  task automatic test_load_use();
    id3(1, 1, 1, 4, 0, 0, 0, 0, 0);
    step();
    id3(1, 1, 0, 7, 0, 4, 0, 1, 0);
    checks++; if (if3.wpcir !== 1'b0) begin errors++; $display("FAIL lu_stall got=%b exp=0", if3.wpcir); end
    checks++; if (if3.fwdb !== 2'd1) begin errors++; $display("FAIL lu_fwdb_stall got=%0d exp=1", if3.fwdb); end
    step();
    checks++; if (if3.bubble_cnt !== 32'd1 || if3.stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got=%0d/%0d exp=1/1", if3.bubble_cnt, if3.stall_cnt); end
    checks++; if (if3.wpcir !== 1'b1 || if3.fwdb !== 2'd2) begin errors++; $display("FAIL lu_resume got=%b/%0d exp=1/2", if3.wpcir, if3.fwdb); end
    step();
    checks++; if (if3.slot_valid !== 3'b101) begin errors++; $display("FAIL lu_slots got=%b exp=101", if3.slot_valid); end
    drain3();
  endtask

  task automatic test_youngest();
    id3(1, 1, 0, 5, 0, 0, 0, 0, 0); step();
    id3(1, 1, 0, 9, 0, 0, 0, 0, 0); step();
    id3(1, 1, 0, 5, 0, 0, 0, 0, 0); step();
    id3(1, 0, 0, 0, 5, 9, 1, 1, 0);
    checks++; if (if3.fwda !== 2'd1) begin errors++; $display("FAIL yng_fwda got=%0d exp=1", if3.fwda); end
    checks++; if (if3.fwdb !== 2'd2) begin errors++; $display("FAIL yng_fwdb got=%0d exp=2", if3.fwdb); end
    checks++; if (if3.slot_valid !== 3'b111 || if3.wpcir !== 1'b1) begin errors++; $display("FAIL yng_state got=%b/%b exp=111/1", if3.slot_valid, if3.wpcir); end
    step();
    drain3();
  endtask

  task automatic test_flush();
    id3(1, 1, 1, 6, 0, 0, 0, 0, 0); step();
    id3(1, 1, 0, 8, 6, 0, 1, 0, 1);
    checks++; if (if3.wpcir !== 1'b1) begin errors++; $display("FAIL fl_wpcir got=%b exp=1", if3.wpcir); end
    step();
    checks++; if (if3.slot_valid !== 3'b010) begin errors++; $display("FAIL fl_slots got=%b exp=010", if3.slot_valid); end
    checks++; if (if3.bubble_cnt !== 32'd2 || if3.stall_cnt !== 32'd1) begin errors++; $display("FAIL fl_cnt got=%0d/%0d exp=2/1", if3.bubble_cnt, if3.stall_cnt); end
    drain3();
  endtask

  task automatic test_r0();
    id3(1, 1, 1, 0, 0, 0, 0, 0, 0); step();
    checks++; if (if3.slot_valid !== 3'b001) begin errors++; $display("FAIL r0_slot got=%b exp=001", if3.slot_valid); end
    id3(1, 1, 0, 0, 0, 0, 1, 1, 0);
    checks++; if (if3.wpcir !== 1'b1 || if3.fwda !== 2'd0 || if3.fwdb !== 2'd0) begin errors++; $display("FAIL r0_fwd got=%b/%0d/%0d exp=1/0/0", if3.wpcir, if3.fwda, if3.fwdb); end
    step();
    checks++; if (if3.stall_cnt !== 32'd1) begin errors++; $display("FAIL r0_stall_cnt got=%0d exp=1", if3.stall_cnt); end
    drain3();
  endtask

  task automatic test_reset_mid_stall();
    id3(1, 1, 1, 4, 0, 0, 0, 0, 0); step();
    id3(1, 0, 0, 0, 4, 0, 1, 0, 0);
    checks++; if (if3.wpcir !== 1'b0) begin errors++; $display("FAIL rms_stall got=%b exp=0", if3.wpcir); end
    rst3 = 1;
    step();
    checks++; if (if3.slot_valid !== 3'b000) begin errors++; $display("FAIL rms_slots got=%b exp=000", if3.slot_valid); end
    checks++; if (if3.stall_cnt !== 32'd0 || if3.bubble_cnt !== 32'd0) begin errors++; $display("FAIL rms_cnt got=%0d/%0d exp=0/0", if3.stall_cnt, if3.bubble_cnt); end
    checks++; if (if3.wpcir !== 1'b1 || if3.fwda !== 2'd0) begin errors++; $display("FAIL rms_out got=%b/%0d exp=1/0", if3.wpcir, if3.fwda); end
    rst3 = 0;
    drain3();
  endtask

  task automatic test_deep_pipe();
    id4(1, 1, 1, 4, 0, 0, 0, 0, 0); step();
    id4(1, 0, 0, 0, 0, 4, 0, 1, 0);
    checks++; if (if4.wpcir !== 1'b0 || if4.fwdb !== 3'd1) begin errors++; $display("FAIL deep_s1 got=%b/%0d exp=0/1", if4.wpcir, if4.fwdb); end
    step();
    checks++; if (if4.wpcir !== 1'b0 || if4.fwdb !== 3'd2) begin errors++; $display("FAIL deep_s2 got=%b/%0d exp=0/2", if4.wpcir, if4.fwdb); end
    step();
    checks++; if (if4.wpcir !== 1'b1 || if4.fwdb !== 3'd3) begin errors++; $display("FAIL deep_s3 got=%b/%0d exp=1/3", if4.wpcir, if4.fwdb); end
    checks++; if (if4.stall_cnt !== 32'd2 || if4.bubble_cnt !== 32'd2) begin errors++; $display("FAIL deep_cnt got=%0d/%0d exp=2/2", if4.stall_cnt, if4.bubble_cnt); end
    step();
    id4(1, 1, 1, 2, 0, 0, 0, 0, 0); step();
    id4(1, 0, 0, 0, 2, 0, 1, 0, 0);
    checks++; if (if4.wpcir !== 1'b0) begin errors++; $display("FAIL deep_rms_stall got=%b exp=0", if4.wpcir); end
    rst4 = 1;
    step();
    checks++; if (if4.slot_valid !== 4'b0000 || if4.wpcir !== 1'b1) begin errors++; $display("FAIL deep_rms got=%b/%b exp=0000/1", if4.slot_valid, if4.wpcir); end
    checks++; if (if4.stall_cnt !== 32'd0 || if4.bubble_cnt !== 32'd0) begin errors++; $display("FAIL deep_rms_cnt got=%0d/%0d exp=0/0", if4.stall_cnt, if4.bubble_cnt); end
    rst4 = 0;
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_flush();
    test_r0();
    test_reset_mid_stall();
    test_deep_pipe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
